// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI transfer controller slice.
package spi_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, FIN} xfer_state_t;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;

  function automatic int len_w(input int maxlen);
    return $clog2(maxlen) + 1;
  endfunction

endpackage

// File: rtl/spi_edge_det.sv
// Registered rise/fall detector: compares a signal against its value one clk earlier.
module spi_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic q;

  // NOTE: non-blocking assignment, so q always holds the pre-edge value of sig.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= RST_VAL;
    else      q <= sig;
  end

  assign rise = sig & ~q;
  assign fall = ~sig & q;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 transfer controller: drives an external clock-pulse generator, owns cs_n,
// shifts MOSI MSB-first and collects MISO into a right-aligned word.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int SPI_MAXLEN = 16,
  parameter int CS_HOLD    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  input  logic [SPI_MAXLEN-1:0]           tx_data,
  input  logic [len_w(SPI_MAXLEN)-1:0]    tx_len,
  output logic                            rx_valid,
  output logic [SPI_MAXLEN-1:0]           rx_data,
  output logic                            rx_err,
  output logic                            gen_start,
  output logic [len_w(2*SPI_MAXLEN)-1:0]  gen_n_pulses,
  input  logic                            gen_done,
  input  logic                            spi_clk,
  output logic                            cs_n,
  output logic                            mosi,
  input  logic                            miso
);

  localparam int   LW   = len_w(SPI_MAXLEN);
  localparam int   PW   = len_w(2*SPI_MAXLEN);
  localparam int   HW   = 3;
  localparam logic CPOL = SPI_MODE0[1];

  xfer_state_t           state;
  logic [SPI_MAXLEN-1:0] shift_reg;
  logic [SPI_MAXLEN-1:0] rx_shift;
  logic [LW-1:0]         bit_cnt;
  logic [LW-1:0]         len_q;
  logic [HW-1:0]         hold_cnt;
  logic                  gen_run;
  logic [LW-1:0]         len_eff;
  logic                  spi_rise, spi_fall, done_rise, done_fall;
  logic                  lead_edge, trail_edge;

  spi_edge_det #(.RST_VAL(1'b0)) u_spi_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (spi_clk),
    .rise (spi_rise),
    .fall (spi_fall)
  );

  // gen_done idles high, so its history resets high to avoid a phantom rise.
  spi_edge_det #(.RST_VAL(1'b1)) u_done_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (gen_done),
    .rise (done_rise),
    .fall (done_fall)
  );

  assign lead_edge  = CPOL ? spi_fall : spi_rise;
  assign trail_edge = CPOL ? spi_rise : spi_fall;
  assign len_eff    = (tx_len > LW'(SPI_MAXLEN)) ? LW'(SPI_MAXLEN) : tx_len;

  // NOTE: every output is a flop in this single block; with no always_comb there is no latch risk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      tx_ready     <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      rx_err       <= 1'b0;
      gen_start    <= 1'b0;
      gen_n_pulses <= '0;
      cs_n         <= 1'b1;
      mosi         <= 1'b0;
      shift_reg    <= '0;
      rx_shift     <= '0;
      bit_cnt      <= '0;
      len_q        <= '0;
      hold_cnt     <= '0;
      gen_run      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_ready  <= 1'b0;
            // Left-align so the next bit to send is always the MSB.
            shift_reg <= tx_data << (LW'(SPI_MAXLEN) - len_eff);
            bit_cnt   <= len_eff;
            len_q     <= len_eff;
            rx_shift  <= '0;
            rx_err    <= 1'b0;
            state     <= (len_eff == '0) ? FIN : SETUP;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        SETUP: begin
          cs_n         <= 1'b0;
          mosi         <= shift_reg[SPI_MAXLEN-1];
          shift_reg    <= shift_reg << 1;
          gen_n_pulses <= PW'({len_q, 1'b0});
          gen_start    <= 1'b1;
          gen_run      <= 1'b0;
          state        <= XFER;
        end
        XFER: begin
          if (done_fall) gen_run <= 1'b1;
          if (lead_edge) begin
            rx_shift <= {rx_shift[SPI_MAXLEN-2:0], miso};
            bit_cnt  <= bit_cnt - LW'(1);
          end
          // A done rise only counts once the generator has actually started running.
          if ((gen_run && done_rise) || (trail_edge && bit_cnt == '0)) begin
            rx_err    <= (bit_cnt != '0);
            gen_start <= 1'b0;
            hold_cnt  <= '0;
            state     <= HOLD;
          end else if (trail_edge) begin
            mosi      <= shift_reg[SPI_MAXLEN-1];
            shift_reg <= shift_reg << 1;
          end
        end
        HOLD: begin
          if (hold_cnt == HW'(CS_HOLD - 1)) state <= FIN;
          else                              hold_cnt <= hold_cnt + HW'(1);
        end
        FIN: begin
          cs_n     <= 1'b1;
          rx_valid <= 1'b1;
          rx_data  <= rx_shift;
          mosi     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
